// File: rtl/pc_ctrl.sv
// Program counter controller: next-PC selection (trap/stall/ret/jump/branch/sequential)
// with a circular return-address stack and trap EPC capture.
module pc_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     STEP      = 1,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0010),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               branch,
  input  logic                               zero,
  input  logic [XLEN-1:0]                    br_target,
  input  logic                               jump,
  input  logic [XLEN-1:0]                    jmp_target,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               trap,
  output logic [XLEN-1:0]                    pc,
  output logic [XLEN-1:0]                    pc_inc,
  output logic [XLEN-1:0]                    epc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_empty,
  output logic                               ras_full,
  output logic                               ras_underflow
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [PW-1:0]   sp_q, sp_d, sp_inc, sp_dec;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            und_q, und_d;
  logic            stack_empty, stack_full;
  logic            do_push;

  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] ras_wdata;

  // sp_q is the next write slot; when full it also indexes the oldest entry.
  assign sp_inc      = (sp_q == PW'(RAS_DEPTH - 1)) ? '0 : sp_q + PW'(1);
  assign sp_dec      = (sp_q == '0) ? PW'(RAS_DEPTH - 1) : sp_q - PW'(1);
  assign stack_empty = (cnt_q == '0);
  assign stack_full  = (cnt_q == CW'(RAS_DEPTH));

  assign pc            = pc_q;
  assign pc_inc        = pc_q + XLEN'(STEP);
  assign epc           = epc_q;
  assign ras_count     = cnt_q;
  assign ras_empty     = stack_empty;
  assign ras_full      = stack_full;
  assign ras_underflow = und_q;

  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    und_d     = 1'b0;
    do_push   = 1'b0;
    ras_we    = 1'b0;
    ras_waddr = sp_q;
    ras_wdata = pc_inc;

    if (trap) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
    end else if (!stall) begin
      if (ret) begin
        if (!stack_empty) begin
          pc_d = ras_mem_q[sp_dec];
          // call+ret swaps the top entry in place instead of pop-then-push
          if (call) begin
            ras_we    = 1'b1;
            ras_waddr = sp_dec;
          end else begin
            sp_d  = sp_dec;
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          pc_d    = pc_inc;
          und_d   = 1'b1;
          do_push = call;
        end
      end else if (jump) begin
        pc_d    = jmp_target;
        do_push = call;
      end else if (branch && zero) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_inc;
      end
    end

    if (do_push) begin
      ras_we    = 1'b1;
      ras_waddr = sp_q;
      sp_d      = sp_inc;
      if (!stack_full) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      und_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      und_q <= und_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_mem_q[ras_waddr] <= ras_wdata;
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: queue-based reference model compared every cycle,
// plus directed literal checks, and an 8-bit instance for wrap and reset-vector checks.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, branch, zero, jump, call, ret, trap;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc, pc_inc, epc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_underflow;

  logic        r8, j8;
  logic [7:0]  jt8;
  logic [7:0]  pc8, pc_inc8, epc8;
  logic [2:0]  cnt8;
  logic        emp8, full8, und8;
  logic        zero_b = 1'b0;
  logic [7:0]  zero8 = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.XLEN(32), .STEP(1), .RESET_VEC(32'h0), .TRAP_VEC(32'h10), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
    .br_target(br_target), .jump(jump), .jmp_target(jmp_target), .call(call),
    .ret(ret), .trap(trap), .pc(pc), .pc_inc(pc_inc), .epc(epc),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow)
  );

  pc_ctrl #(.XLEN(8), .STEP(1), .RESET_VEC(8'h20), .TRAP_VEC(8'h10), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .reset(r8), .stall(zero_b), .branch(zero_b), .zero(zero_b),
    .br_target(zero8), .jump(j8), .jmp_target(jt8), .call(zero_b),
    .ret(zero_b), .trap(zero_b), .pc(pc8), .pc_inc(pc_inc8), .epc(epc8),
    .ras_count(cnt8), .ras_empty(emp8), .ras_full(full8),
    .ras_underflow(und8)
  );

  // Reference model: return stack as a queue, newest at the back.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic        m_und = 1'b0;
  logic [31:0] m_stack [$];
  logic [31:0] m_tmp;

  task automatic m_push(input logic [31:0] v);
    if (m_stack.size() == 4) void'(m_stack.pop_front());
    m_stack.push_back(v);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_und = 1'b0; m_stack.delete();
    end else begin
      m_und = 1'b0;
      if (trap) begin
        m_epc = m_pc; m_pc = 32'h10;
      end else if (stall) begin
        m_und = 1'b0;
      end else if (ret) begin
        if (m_stack.size() > 0) begin
          m_tmp = m_stack[m_stack.size()-1];
          if (call) m_stack[m_stack.size()-1] = m_pc + 32'd1;
          else void'(m_stack.pop_back());
          m_pc = m_tmp;
        end else begin
          m_und = 1'b1;
          if (call) m_push(m_pc + 32'd1);
          m_pc = m_pc + 32'd1;
        end
      end else if (jump) begin
        if (call) m_push(m_pc + 32'd1);
        m_pc = jmp_target;
      end else if (branch && zero) begin
        m_pc = br_target;
      end else begin
        m_pc = m_pc + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pc", pc, m_pc);
    chk("model_pc_inc", pc_inc, m_pc + 32'd1);
    chk("model_epc", epc, m_epc);
    chk("model_count", {29'b0, ras_count}, m_stack.size());
    chk("model_empty", {31'b0, ras_empty}, {31'b0, m_stack.size() == 0});
    chk("model_full", {31'b0, ras_full}, {31'b0, m_stack.size() == 4});
    chk("model_underflow", {31'b0, ras_underflow}, {31'b0, m_und});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic st, input logic br, input logic z, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic c, input logic r,
                     input logic t);
    stall = st; branch = br; zero = z; br_target = bt;
    jump = j; jmp_target = jt; call = c; ret = r; trap = t;
    tick();
    stall = 0; branch = 0; zero = 0; br_target = 0;
    jump = 0; jmp_target = 0; call = 0; ret = 0; trap = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; stall = 0; branch = 0; zero = 0; br_target = 0;
    jump = 0; jmp_target = 0; call = 0; ret = 0; trap = 0;
    r8 = 1; j8 = 0; jt8 = 0;
    tick();
    chk("reset_pc", pc, 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_count", {29'b0, ras_count}, 32'd0);
    chk("reset_pc8", {24'b0, pc8}, 32'h20);
    reset = 0;

    for (int unsigned i = 1; i <= 3; i++) begin
      idle();
      chk("idle_seq", pc, i);
    end
    chk("idle_empty", {31'b0, ras_empty}, 32'd1);

    idle(); idle();
    chk("pc_5", pc, 32'd5);
    cyc(0, 1, 0, 32'd99, 0, 0, 0, 0, 0);
    chk("branch_not_taken", pc, 32'd6);
    cyc(0, 1, 1, 32'd40, 0, 0, 0, 0, 0);
    chk("branch_taken", pc, 32'd40);

    cyc(0, 0, 0, 0, 1, 32'd10, 0, 0, 0);
    chk("jump_10", pc, 32'd10);
    cyc(0, 0, 0, 0, 1, 32'd100, 1, 0, 0);
    chk("call_pc", pc, 32'd100);
    chk("call_count", {29'b0, ras_count}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("ret_pc", pc, 32'd11);
    chk("ret_count", {29'b0, ras_count}, 32'd0);

    cyc(0, 0, 0, 0, 1, 32'd1, 0, 0, 0);
    for (int unsigned i = 2; i <= 5; i++) cyc(0, 0, 0, 0, 1, i, 1, 0, 0);
    chk("full_after_4", {31'b0, ras_full}, 32'd1);
    cyc(0, 0, 0, 0, 1, 32'd50, 1, 0, 0);
    chk("overflow_count", {29'b0, ras_count}, 32'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("ret_chain", pc, 32'd6 - i);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("underflow_pc", pc, 32'd4);
    chk("underflow_pulse", {31'b0, ras_underflow}, 32'd1);
    idle();
    chk("underflow_clear", {31'b0, ras_underflow}, 32'd0);

    cyc(0, 0, 0, 0, 1, 32'd60, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'd77, 1, 1, 0);
    chk("callret_pc", pc, 32'd6);
    chk("callret_count", {29'b0, ras_count}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("callret_replaced", pc, 32'd61);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("callret_empty_pc", pc, 32'd62);
    chk("callret_empty_und", {31'b0, ras_underflow}, 32'd1);
    chk("callret_empty_cnt", {29'b0, ras_count}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("callret_empty_pop", pc, 32'd62);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("call_alone_cnt", {29'b0, ras_count}, 32'd0);

    cyc(0, 0, 0, 0, 1, 32'd7, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'd90, 0, 0, 1);
    chk("trap_pc", pc, 32'h10);
    chk("trap_epc", epc, 32'd7);
    for (int unsigned i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 32'd90, 0, 1, 0);
    chk("stall_pc", pc, 32'h10);
    chk("stall_und", {31'b0, ras_underflow}, 32'd0);
    idle();
    chk("after_stall", pc, 32'h11);

    stall = 1;
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("async_reset_pc", pc, 32'd0);
    chk("async_reset_epc", epc, 32'd0);
    reset = 0; stall = 0;
    tick();
    chk("post_reset_pc", pc, 32'd1);

    r8 = 0;
    j8 = 1; jt8 = 8'hFF;
    tick();
    j8 = 0;
    chk("pc8_255", {24'b0, pc8}, 32'hFF);
    tick();
    chk("pc8_wrap", {24'b0, pc8}, 32'h00);
    tick();
    #1;
    r8 = 1;
    #1;
    chk("pc8_async_reset", {24'b0, pc8}, 32'h20);
    r8 = 0;
    tick();
    chk("pc8_after_reset", {24'b0, pc8}, 32'h21);

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
